// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one BRAM port between CPU load/store and video reads
// Optional feature macro: BRAM_ARB_VID_PRIO_EN (video wins ties unless the CPU is starved)
// Ports:
//   clk, reset (async, active-low)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_gnt/cpu_rvalid/cpu_rdata
//   vid_req/vid_addr                  -> vid_gnt/vid_rvalid/vid_rdata
//   bram_en/bram_we/bram_addr/bram_wdata -> BRAM, bram_rdata <- BRAM
//   busy: an access is in flight
module bram_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
`ifdef BRAM_ARB_VID_PRIO_EN
  , parameter int STARVE_MAX = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_n;
  logic owner;
  logic [1:0] lat_cnt;
  logic cpu_wins_tie, pick_cpu, grant;
  assign pick_cpu = cpu_req && (!vid_req || cpu_wins_tie);
  assign grant = (state == IDLE) && (cpu_req || vid_req);
`ifdef BRAM_ARB_VID_PRIO_EN
  logic [7:0] cpu_wait_cnt;
  // Once starved the CPU wins the tie, so the count never passes STARVE_MAX.
  assign cpu_wins_tie = cpu_wait_cnt >= 8'(STARVE_MAX);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cpu_wait_cnt <= '0;
    else if (state == IDLE && cpu_req) cpu_wait_cnt <= pick_cpu ? '0 : cpu_wait_cnt + 8'd1;
`else
  // owner doubles as last_owner: reset to video so the CPU wins the first tie.
  assign cpu_wins_tie = !owner;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE  ? (grant ? ISSUE : IDLE) :
              state == ISSUE ? (bram_we ? IDLE : WAIT) :
              (state == WAIT && lat_cnt != 2'd0) ? WAIT : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      cpu_gnt    <= 1'b0;
      vid_gnt    <= 1'b0;
      owner      <= 1'b0;
      lat_cnt    <= '0;
    end else begin
      if (grant) begin
        bram_en    <= 1'b1;
        bram_we    <= pick_cpu && cpu_we;
        bram_addr  <= pick_cpu ? cpu_addr : vid_addr;
        bram_wdata <= pick_cpu ? cpu_wdata : '0;
        cpu_gnt    <= pick_cpu;
        vid_gnt    <= !pick_cpu;
        owner      <= pick_cpu;
      end else begin
        bram_en <= 1'b0;
        bram_we <= 1'b0;
        cpu_gnt <= 1'b0;
        vid_gnt <= 1'b0;
      end
      if (state == ISSUE) lat_cnt <= 2'(RD_LAT - 1);
      else if (state == WAIT && lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
    end
  assign cpu_rvalid = (state == WAIT) && (lat_cnt == 2'd0) && owner;
  assign vid_rvalid = (state == WAIT) && (lat_cnt == 2'd0) && !owner;
  assign cpu_rdata  = bram_rdata;
  assign vid_rdata  = bram_rdata;
  assign busy       = state != IDLE;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed scoreboard bench for bram_port_arbiter
module tb_bram_port_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0, vid_req = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, vid_addr = '0;
  logic cpu_gnt, cpu_rvalid, vid_gnt, vid_rvalid, bram_en, bram_we, busy;
  logic [15:0] cpu_rdata, vid_rdata, bram_addr, bram_wdata, bram_rdata;
  logic c2_req = 1'b0, z1 = 1'b0;
  logic [15:0] c2_addr = '0, z16 = '0;
  logic c2_gnt, c2_rvalid, v2_gnt, v2_rvalid, b2_en, b2_we, busy2;
  logic [15:0] c2_rdata, v2_rdata, b2_addr, b2_wdata, b2_rdata;
  int checks = 0, errors = 0, rvc = 0;
  logic [16:0] sb[$];
  bit gl[$];
  logic [15:0] ref_mem[logic [15:0]];
  logic cpu_hold = 1'b0, vid_hold = 1'b0, saw_c = 1'b0, saw_v = 1'b0;
  logic [15:0] mem[0:4095];
  logic [4095:0] wr_mask = '0;
  logic [15:0] rd1 = '0, p1 = '0, p2 = '0;
`ifdef BRAM_ARB_VID_PRIO_EN
  bit exp_seq[6] = '{0, 0, 0, 1, 0, 0};
  int wait_bound = 3;
`else
  bit exp_seq[6] = '{1, 0, 1, 0, 1, 0};
  int wait_bound = 1;
`endif

  always #5 clk = ~clk;

  bram_port_arbiter #(.RD_LAT(1)
`ifdef BRAM_ARB_VID_PRIO_EN
    , .STARVE_MAX(3)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid),
    .vid_rdata(vid_rdata), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .busy(busy));

  bram_port_arbiter #(.RD_LAT(2)) dut2 (
    .clk(clk), .reset(reset),
    .cpu_req(c2_req), .cpu_we(z1), .cpu_addr(c2_addr), .cpu_wdata(z16),
    .cpu_gnt(c2_gnt), .cpu_rvalid(c2_rvalid), .cpu_rdata(c2_rdata),
    .vid_req(z1), .vid_addr(z16), .vid_gnt(v2_gnt), .vid_rvalid(v2_rvalid),
    .vid_rdata(v2_rdata), .bram_en(b2_en), .bram_we(b2_we), .bram_addr(b2_addr),
    .bram_wdata(b2_wdata), .bram_rdata(b2_rdata), .busy(busy2));

  // BRAM models: unwritten words read back as addr ^ 16'h5a5a
  always @(posedge clk)
    if (bram_en) begin
      if (bram_we) begin
        mem[bram_addr[11:0]] <= bram_wdata;
        wr_mask[bram_addr[11:0]] <= 1'b1;
      end
      rd1 <= wr_mask[bram_addr[11:0]] ? mem[bram_addr[11:0]] : bram_addr ^ 16'h5a5a;
    end
  assign bram_rdata = rd1;
  always @(posedge clk) begin
    if (b2_en) p1 <= b2_addr ^ 16'h5a5a;
    p2 <= p1;
  end
  assign b2_rdata = p2;

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : a ^ 16'h5a5a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic cq, vq;
    logic [16:0] e;
    cq = cpu_req;
    vq = vid_req;
    @(posedge clk); #1;
    saw_c = cpu_gnt;
    saw_v = vid_gnt;
    if (cpu_gnt) begin
      chk("cpu_gnt_needs_req", cq, 1);
      chk("single_gnt", vid_gnt, 0);
      gl.push_back(1'b1);
      if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      else sb.push_back({1'b1, ref_rd(cpu_addr)});
      if (!cpu_hold) cpu_req = 1'b0;
    end
    if (vid_gnt) begin
      chk("vid_gnt_needs_req", vq, 1);
      gl.push_back(1'b0);
      sb.push_back({1'b0, ref_rd(vid_addr)});
      if (!vid_hold) vid_req = 1'b0;
    end
    if (cpu_rvalid || vid_rvalid) begin
      rvc++;
      if (sb.size() == 0) chk("rvalid_unexpected", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("rv_owner", {cpu_rvalid, vid_rvalid}, {e[16], !e[16]});
        chk("rv_data", e[16] ? cpu_rdata : vid_rdata, e[15:0]);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (busy || sb.size() != 0); i++) tick();
    chk("drain", {busy, sb.size() != 0}, 0);
  endtask

  task automatic cpu_op(input logic we, input logic [15:0] a, input logic [15:0] d);
    bit got = 0;
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = saw_c;
    end
    chk("op_gnt", got, 1);
    drain();
  endtask

  initial begin
    int n, r0;
    bit got;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {cpu_gnt, vid_gnt, cpu_rvalid, vid_rvalid, bram_en, bram_we, busy}, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_wdata", bram_wdata, 0);
    reset = 1'b1;
    // both requesting continuously: first tie goes to the CPU, then alternate
    cpu_we = 1'b0; cpu_addr = 16'h0100; vid_addr = 16'h0200;
    cpu_hold = 1'b1; vid_hold = 1'b1; cpu_req = 1'b1; vid_req = 1'b1;
    gl.delete();
    r0 = rvc;
    for (int i = 0; i < 100 && gl.size() < 6; i++) tick();
    cpu_req = 1'b0; vid_req = 1'b0; cpu_hold = 1'b0; vid_hold = 1'b0;
    chk("t3_count", gl.size(), 6);
    if (gl.size() == 6)
      for (int i = 0; i < 6; i++) chk($sformatf("t3_gnt%0d", i), gl[i], exp_seq[i]);
    drain();
    chk("t3_rvalids", rvc - r0, 6);
    // store then load back
    cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF; cpu_req = 1'b1;
    tick();
    chk("t1_gnt", {cpu_gnt, vid_gnt}, 2'b10);
    chk("t1_en_we", {bram_en, bram_we}, 2'b11);
    chk("t1_addr", bram_addr, 16'h0010);
    chk("t1_wdata", bram_wdata, 16'hBEEF);
    tick();
    chk("t1_wr_done", {bram_en, bram_we, cpu_gnt, busy}, 0);
    cpu_we = 1'b0; cpu_req = 1'b1;
    tick();
    chk("t1_ld_gnt", {cpu_gnt, bram_en, bram_we, busy}, 4'b1101);
    tick();
    chk("t1_rv", {cpu_rvalid, vid_rvalid, busy}, 3'b101);
    chk("t1_rdata", cpu_rdata, 16'hBEEF);
    tick();
    chk("t1_done", {cpu_rvalid, busy}, 0);
    // RD_LAT=2 instance: rvalid two cycles after gnt
    c2_addr = 16'h0033; c2_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (c2_gnt) c2_req = 1'b0;
      chk($sformatf("t2_gnt%0d", i), c2_gnt, 32'(i == 0));
      chk($sformatf("t2_busy%0d", i), busy2, 32'(i < 3));
      chk($sformatf("t2_rv%0d", i), c2_rvalid, 32'(i == 2));
      chk($sformatf("t2_vrv%0d", i), v2_rvalid, 0);
      if (i == 2) chk("t2_rdata", c2_rdata, 16'h0033 ^ 16'h5a5a);
    end
    // video streaming, one CPU request must get through quickly
    vid_hold = 1'b1; vid_addr = 16'h0300; vid_req = 1'b1;
    repeat (3) tick();
    cpu_we = 1'b0; cpu_addr = 16'h0011; cpu_req = 1'b1;
    n = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (saw_c) got = 1;
      else if (saw_v) n++;
    end
    chk("t4_cpu_gnt", got, 1);
    chk("t4_wait_bound", n <= wait_bound, 1);
    vid_hold = 1'b0; vid_req = 1'b0;
    drain();
    // reset during WAIT of a video read
    vid_addr = 16'h0444; vid_req = 1'b1;
    tick();
    chk("t5_vgnt", vid_gnt, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("t5_ctrl", {cpu_gnt, vid_gnt, cpu_rvalid, vid_rvalid, bram_en, bram_we, busy}, 0);
    chk("t5_addr", bram_addr, 0);
    chk("t5_wdata", bram_wdata, 0);
    sb.delete();
    #3;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t5_no_vrv%0d", i), vid_rvalid, 0);
    end
    r0 = rvc;
    cpu_op(1'b0, 16'h0010, 16'h0000);
    chk("t5_cpu_rv", rvc - r0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
